kmp_ff_gen: RTL and testbench

//  Builds the KMP failure table for one pattern and hands it to the KMP_pe

---
 rtl/kmp_ff_gen_pkg.sv | 24 ++
 rtl/kmp_ff_gen.sv | 120 ++++++++++++
 tb/tb_kmp_ff_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/kmp_ff_gen_pkg.sv
// Shared constants and state encoding for the KMP failure-table generator.
// The top level and its testbench both import this package.
package kmp_ff_gen_pkg;

  localparam int MAX_PATTERN = 8;
  localparam int BYTE        = 8;
  localparam int MAX_PAT_ADD = 4;
  localparam int IDX_W       = $clog2(MAX_PATTERN);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    INIT = 4'b0010,
    COMP = 4'b0100,
    DONE = 4'b1000
  } state_t;

  // Lengths beyond the table are truncated to the last storable byte.
  function automatic logic [MAX_PAT_ADD-1:0] clampLast(input logic [MAX_PAT_ADD-1:0] last);
    if (last > MAX_PAT_ADD'(MAX_PATTERN - 1))
      return MAX_PAT_ADD'(MAX_PATTERN - 1);
    return last;
  endfunction

endpackage

// File: rtl/kmp_ff_gen.sv
// Builds the KMP failure table for one latched pattern, one comparison step per
// cycle, and holds it for the PE array under the input_valid/output_valid handshake.
module kmp_ff_gen
  import kmp_ff_gen_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MAX_PATTERN*BYTE-1:0]      pat_input,
  input  logic [MAX_PAT_ADD-1:0]           pat_last_idx,
  input  logic                             input_valid,
  output logic                             output_valid,
  output logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result
);

  state_t                 r_state;
  logic                   r_valid;
  logic [BYTE-1:0]        r_pat [MAX_PATTERN];
  logic [MAX_PAT_ADD-1:0] r_ff  [MAX_PATTERN];
  logic [MAX_PAT_ADD-1:0] r_i;
  logic [MAX_PAT_ADD-1:0] r_k;
  logic [MAX_PAT_ADD-1:0] r_last;

  logic [IDX_W-1:0]       w_iIdx;
  logic [IDX_W-1:0]       w_kIdx;
  logic [IDX_W-1:0]       w_kPrev;
  logic                   w_match;
  logic                   w_kZero;
  logic                   w_writeLast;
  logic [MAX_PAT_ADD-1:0] w_clampLast;

  // i and k never exceed MAX_PATTERN-1 while a step is taken, so the low bits index safely.
  assign w_iIdx      = r_i[IDX_W-1:0];
  assign w_kIdx      = r_k[IDX_W-1:0];
  assign w_kPrev     = IDX_W'(r_k - MAX_PAT_ADD'(1));
  assign w_match     = (r_pat[w_iIdx] == r_pat[w_kIdx]);
  assign w_kZero     = (r_k == '0);
  assign w_writeLast = (w_match || w_kZero) && (r_i == r_last);
  assign w_clampLast = clampLast(pat_last_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (input_valid) r_state <= INIT;
        end
        INIT: begin
          if (!input_valid) begin
            r_state <= IDLE;
          end else if (w_clampLast == '0) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end else begin
            r_state <= COMP;
          end
        end
        COMP: begin
          if (!input_valid) begin
            r_state <= IDLE;
          end else if (w_writeLast) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (!input_valid) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MAX_PATTERN; j++) begin
        r_pat[j] <= '0;
        r_ff[j]  <= '0;
      end
      r_i    <= '0;
      r_k    <= '0;
      r_last <= '0;
    end else if (input_valid && r_state == INIT) begin
      for (int j = 0; j < MAX_PATTERN; j++) begin
        r_pat[j] <= pat_input[j*BYTE +: BYTE];
        r_ff[j]  <= '0;
      end
      r_last <= w_clampLast;
      r_i    <= MAX_PAT_ADD'(1);
      r_k    <= '0;
    end else if (input_valid && r_state == COMP) begin
      // A mismatch with k>0 only retreats k; i stays put until a write happens.
      if (w_match) begin
        r_ff[w_iIdx] <= r_k + MAX_PAT_ADD'(1);
        r_k          <= r_k + MAX_PAT_ADD'(1);
        r_i          <= r_i + MAX_PAT_ADD'(1);
      end else if (!w_kZero) begin
        r_k <= r_ff[w_kPrev];
      end else begin
        r_ff[w_iIdx] <= '0;
        r_i          <= r_i + MAX_PAT_ADD'(1);
      end
    end
  end

  assign output_valid = r_valid;

  for (genvar g = 0; g < MAX_PATTERN; g++) begin : g_pack
    assign ff_result[g*MAX_PAT_ADD +: MAX_PAT_ADD] = r_ff[g];
  end

endmodule

// File: tb/tb_kmp_ff_gen.sv
// Scoreboard bench for kmp_ff_gen: requests push expected tables and completion
// edges; a monitor pops and compares on every output_valid rising.
module tb_kmp_ff_gen;
  import kmp_ff_gen_pkg::*;

  localparam int PATW = MAX_PATTERN * BYTE;
  localparam int FFW  = MAX_PAT_ADD * MAX_PATTERN;

  typedef struct {
    logic [FFW-1:0] ff;
    int             edgeNum;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [PATW-1:0] pat_input;
  logic [MAX_PAT_ADD-1:0] pat_last_idx;
  logic            input_valid;
  logic            output_valid;
  logic [FFW-1:0]  ff_result;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   edgeCount   = 0;
  logic prevValid   = 1'b0;

  kmp_ff_gen dut (
    .clk          (clk),
    .reset        (reset),
    .pat_input    (pat_input),
    .pat_last_idx (pat_last_idx),
    .input_valid  (input_valid),
    .output_valid (output_valid),
    .ff_result    (ff_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [PATW-1:0] packPat(input string s);
    logic [PATW-1:0] v = '0;
    for (int j = 0; j < s.len() && j < MAX_PATTERN; j++) v[j*BYTE +: BYTE] = s[j];
    return v;
  endfunction

  function automatic logic [FFW-1:0] packFf(input string d);
    logic [FFW-1:0] v = '0;
    for (int j = 0; j < d.len() && j < MAX_PATTERN; j++)
      v[j*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(d[j] - 8'd48);
    return v;
  endfunction

  function automatic int naiveCount(input string pat, input string txt);
    int c = 0;
    for (int t = 0; t + pat.len() <= txt.len(); t++)
      if (txt.substr(t, t + pat.len() - 1) == pat) c++;
    return c;
  endfunction

  // Software KMP search driven by the table the DUT produced; guard stops a bad table looping.
  function automatic int kmpCount(input string pat, input string txt, input logic [FFW-1:0] ff);
    int k = 0, c = 0, guard = 0;
    for (int t = 0; t < txt.len(); t++) begin
      while (k > 0 && k < pat.len() && pat[k] != txt[t] && guard < 1000) begin
        k = int'(ff[(k-1)*MAX_PAT_ADD +: MAX_PAT_ADD]);
        guard++;
      end
      if (k < pat.len() && pat[k] == txt[t]) k++;
      if (k >= pat.len()) begin
        c++;
        k = int'(ff[(pat.len()-1)*MAX_PAT_ADD +: MAX_PAT_ADD]);
      end
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (output_valid && !prevValid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedValid: output_valid=1 at edge %0d, expected no completion", edgeCount);
      end else begin
        e = expQ.pop_front();
        checkOutput("ffResult", ff_result, e.ff);
        checkOutput("latencyEdge", edgeCount, e.edgeNum);
      end
    end
    prevValid = output_valid;
  end

  // Called at a negedge; raises a request, waits for completion, holds, then drops.
  task automatic applyStimulus(input string pat, input int last, input string ffDigits,
                               input int lat, input int hold, input string txt);
    int    n = 0;
    int    lastEff;
    string patEff;
    pat_input    = packPat(pat);
    pat_last_idx = MAX_PAT_ADD'(last);
    input_valid  = 1'b1;
    expQ.push_back('{packFf(ffDigits), edgeCount + lat});
    while (!output_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!output_valid) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout %s: output_valid=0 after %0d cycles, expected 1", pat, n);
      if (expQ.size() != 0) void'(expQ.pop_back());
      input_valid = 1'b0;
      @(negedge clk);
      return;
    end
    if (txt != "") begin
      lastEff = (last > MAX_PATTERN - 1) ? MAX_PATTERN - 1 : last;
      patEff  = pat.substr(0, lastEff);
      checkOutput("kmpCrossCheck", kmpCount(patEff, txt, ff_result), naiveCount(patEff, txt));
    end
    repeat (hold) begin
      @(negedge clk);
      checkOutput("holdValid", {31'd0, output_valid}, 32'd1);
      checkOutput("holdFf", ff_result, packFf(ffDigits));
    end
    input_valid = 1'b0;
    @(negedge clk);
    checkOutput("validDrop", {31'd0, output_valid}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    pat_input    = '0;
    pat_last_idx = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("resetValid", {31'd0, output_valid}, 32'd0);
    checkOutput("resetFf", ff_result, 32'd0);

    applyStimulus("aaaa",    3, "0123",    5,  1, "");
    applyStimulus("aabaaab", 6, "0101223", 10, 1, "aabaaabaaabaabaaab");
    applyStimulus("abcd",    3, "0000",    5,  1, "abcdabcabcd");
    applyStimulus("abcd",    0, "0",       2,  1, "");
    applyStimulus("aaaa",    3, "0123",    5,  5, "");
    applyStimulus("abab",    3, "0012",    5,  1, "abababab");

    // Abort mid-COMP by dropping the request.
    pat_input    = packPat("aabaaab");
    pat_last_idx = MAX_PAT_ADD'(6);
    input_valid  = 1'b1;
    repeat (4) @(negedge clk);
    input_valid = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abortValid", {31'd0, output_valid}, 32'd0);

    // Reset pulse mid-COMP.
    input_valid = 1'b1;
    repeat (4) @(negedge clk);
    reset       = 1'b1;
    input_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midResetValid", {31'd0, output_valid}, 32'd0);
    checkOutput("midResetFf", ff_result, 32'd0);

    applyStimulus("aaaa", 3, "0123", 5, 1, "");
    applyStimulus("aaaaaaaaaa", MAX_PATTERN + 2, "01234567", MAX_PATTERN + 1, 1, "aaaaaaaaaaaa");

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
